// File: rtl/led_scan_ctrl_if.sv
// rtl/led_scan_ctrl_if.sv - frame RAM read port between the LED scan controller and the dual-port RAM
interface led_scan_ctrl_if #(
    parameter int COL_NUM_LOG2 = 7
);
    logic                    dualram_rd_en;
    logic [COL_NUM_LOG2+4:0] dualram_rd_addr;
    logic [15:0]             dualram_rd_dat;

    modport master (
        output dualram_rd_en,
        output dualram_rd_addr,
        input  dualram_rd_dat
    );

    modport slave (
        input  dualram_rd_en,
        input  dualram_rd_addr,
        output dualram_rd_dat
    );
endinterface

// File: rtl/led_scan_ctrl.sv
// rtl/led_scan_ctrl.sv - HUB75 1/16-scan BCM scanner reading RGB565 pixels from the frame RAM
module led_scan_ctrl #(
    parameter int COL_NUM_LOG2 = 7,
    parameter int PWM_BITS     = 4,
    parameter int BASE_ON      = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            scan_enable,
    led_scan_ctrl_if.master ram,
    output logic            led_r0,
    output logic            led_g0,
    output logic            led_b0,
    output logic            led_r1,
    output logic            led_g1,
    output logic            led_b1,
    output logic            led_clk,
    output logic            led_lat,
    output logic            led_oe_n,
    output logic [3:0]      led_row,
    output logic            frame_start,
    output logic            busy
);
    localparam int PLANE_W  = (PWM_BITS > 1) ? $clog2(PWM_BITS) : 1;
    localparam int DISP_MAX = BASE_ON << (PWM_BITS - 1);
    localparam int DISP_W   = $clog2(DISP_MAX + 1);
    // Offset of the lowest kept bit inside each 5-bit colour field
    localparam int K        = 5 - PWM_BITS;

    localparam logic [COL_NUM_LOG2-1:0] COL_ZERO   = '0;
    localparam logic [COL_NUM_LOG2-1:0] COL_LAST   = '1;
    localparam logic [COL_NUM_LOG2-1:0] COL_ONE    = COL_NUM_LOG2'(1);
    localparam logic [PLANE_W-1:0]      PLANE_LAST = PLANE_W'(PWM_BITS - 1);
    localparam logic [PLANE_W-1:0]      PLANE_ONE  = PLANE_W'(1);
    localparam logic [DISP_W-1:0]       DISP_ONE   = DISP_W'(1);
    localparam logic [DISP_W-1:0]       DISP_BASE  = DISP_W'(BASE_ON);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_BLANK,
        S_LATCH,
        S_DISPLAY
    } state_t;

    state_t                  state;
    logic [3:0]              row;
    logic [COL_NUM_LOG2-1:0] col;
    logic [1:0]              ph;
    logic [PLANE_W-1:0]      plane;
    logic [DISP_W-1:0]       disp_cnt;
    logic [2:0]              upper_q;

    // Select the {R,G,B} bits of one BCM plane; G uses the top five of its six bits
    function automatic logic [2:0] pick_rgb(input logic [15:0] pix, input logic [PLANE_W-1:0] p);
        logic [2:0] idx;
        logic [4:0] r5;
        logic [4:0] g5;
        logic [4:0] b5;
        idx = 3'(K) + 3'(p);
        r5  = pix[15:11];
        g5  = pix[10:6];
        b5  = pix[4:0];
        return {r5[idx], g5[idx], b5[idx]};
    endfunction

    // Scan sequencer: every output is registered and set on the edge entering the cycle it describes
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= S_IDLE;
            row                 <= '0;
            col                 <= '0;
            ph                  <= '0;
            plane               <= '0;
            disp_cnt            <= '0;
            upper_q             <= '0;
            ram.dualram_rd_en   <= 1'b0;
            ram.dualram_rd_addr <= '0;
            led_r0              <= 1'b0;
            led_g0              <= 1'b0;
            led_b0              <= 1'b0;
            led_r1              <= 1'b0;
            led_g1              <= 1'b0;
            led_b1              <= 1'b0;
            led_clk             <= 1'b0;
            led_lat             <= 1'b0;
            led_oe_n            <= 1'b1;
            led_row             <= '0;
            frame_start         <= 1'b0;
            busy                <= 1'b0;
        end else begin
            frame_start       <= 1'b0;
            ram.dualram_rd_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (scan_enable) begin
                        state               <= S_SHIFT;
                        row                 <= '0;
                        col                 <= '0;
                        ph                  <= '0;
                        plane               <= '0;
                        frame_start         <= 1'b1;
                        busy                <= 1'b1;
                        ram.dualram_rd_en   <= 1'b1;
                        ram.dualram_rd_addr <= {1'b0, 4'd0, COL_ZERO};
                    end
                end
                S_SHIFT: begin
                    ph <= ph + 2'd1;
                    case (ph)
                        2'd0: begin
                            // Second read of the column fetches the lower-half pixel
                            ram.dualram_rd_en   <= 1'b1;
                            ram.dualram_rd_addr <= {1'b1, row, col};
                        end
                        2'd1: begin
                            upper_q <= pick_rgb(ram.dualram_rd_dat, plane);
                        end
                        2'd2: begin
                            {led_r0, led_g0, led_b0} <= upper_q;
                            {led_r1, led_g1, led_b1} <= pick_rgb(ram.dualram_rd_dat, plane);
                            led_clk                  <= 1'b1;
                        end
                        default: begin
                            led_clk <= 1'b0;
                            if (col == COL_LAST) begin
                                state   <= S_BLANK;
                                col     <= '0;
                                led_row <= row;
                            end else begin
                                col                 <= col + COL_ONE;
                                ram.dualram_rd_en   <= 1'b1;
                                ram.dualram_rd_addr <= {1'b0, row, col + COL_ONE};
                            end
                        end
                    endcase
                end
                S_BLANK: begin
                    if (ph == 2'd1) begin
                        state   <= S_LATCH;
                        ph      <= '0;
                        led_lat <= 1'b1;
                    end else begin
                        ph <= ph + 2'd1;
                    end
                end
                S_LATCH: begin
                    if (ph == 2'd1) begin
                        state    <= S_DISPLAY;
                        ph       <= '0;
                        led_lat  <= 1'b0;
                        led_oe_n <= 1'b0;
                        disp_cnt <= (DISP_BASE << plane) - DISP_ONE;
                    end else begin
                        ph <= ph + 2'd1;
                    end
                end
                S_DISPLAY: begin
                    if (disp_cnt != '0) begin
                        disp_cnt <= disp_cnt - DISP_ONE;
                    end else begin
                        led_oe_n <= 1'b1;
                        col      <= '0;
                        ph       <= '0;
                        if (plane != PLANE_LAST) begin
                            plane               <= plane + PLANE_ONE;
                            state               <= S_SHIFT;
                            ram.dualram_rd_en   <= 1'b1;
                            ram.dualram_rd_addr <= {1'b0, row, COL_ZERO};
                        end else begin
                            // Row boundary: the only point besides IDLE where scan_enable matters
                            plane <= '0;
                            row   <= row + 4'd1;
                            if (scan_enable) begin
                                state               <= S_SHIFT;
                                frame_start         <= (row == 4'd15);
                                ram.dualram_rd_en   <= 1'b1;
                                ram.dualram_rd_addr <= {1'b0, row + 4'd1, COL_ZERO};
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    led_oe_n <= 1'b1;
                    led_lat  <= 1'b0;
                    led_clk  <= 1'b0;
                end
            endcase
        end
    end
endmodule
